// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: one outstanding irom request, output register with a
// 1-entry skid buffer toward decode, and redirect handling that drops stale responses.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic        irom_gnt,
  input  logic        irom_rvalid,
  input  logic [31:0] irom_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } fetch_pkt_t;

  state_t     state_q, state_d;
  logic [31:0] pc_q, f_pc;
  fetch_pkt_t out_q, skid_q, resp_pkt;
  logic       out_vld, skid_vld;
  logic       req_c, hs, resp_live, out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    case (state_q)
      IDLE: begin
        req_c = !redirect && !skid_vld;
        if (req_c && irom_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (irom_rvalid)   state_d = IDLE;
        else if (redirect) state_d = DROP;
      end
      // A redirect here keeps us in DROP; the stale response still closes it out.
      DROP: if (irom_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign irom_req  = req_c && rst_n;
  assign irom_addr = pc_q;
  assign hs        = req_c && irom_gnt;
  assign resp_live = (state_q == WAIT) && irom_rvalid && !redirect;
  assign out_free  = !out_vld || id_ready;
  assign resp_pkt  = '{pc: f_pc, pc4: f_pc + 32'd4, inst: irom_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      f_pc <= RESET_PC;
    end else if (redirect) begin
      pc_q <= {redirect_pc[31:2], 2'b00};
    end else if (hs) begin
      f_pc <= pc_q;
      pc_q <= pc_q + 32'd4;
    end
  end

  // Skid drains ahead of any new response so decode sees program order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      skid_q   <= '0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (redirect) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (out_free) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (resp_live) begin
        out_q   <= resp_pkt;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (resp_live) begin
      skid_q   <= resp_pkt;
      skid_vld <= 1'b1;
    end
  end

  assign id_valid = out_vld;
  assign id_pc    = out_q.pc;
  assign id_pc4   = out_q.pc4;
  assign id_inst  = out_q.inst;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: memory handshake driven by hand, expectations hand-computed.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irom_req;
  logic [31:0] irom_addr;
  logic        irom_gnt;
  logic        irom_rvalid;
  logic [31:0] irom_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_pc4, id_inst;

  int errors = 0;
  int checks = 0;

  if_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .irom_req(irom_req), .irom_addr(irom_addr), .irom_gnt(irom_gnt),
    .irom_rvalid(irom_rvalid), .irom_rdata(irom_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    redirect = 0; redirect_pc = 0; irom_gnt = 0; irom_rvalid = 0; irom_rdata = 0; id_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; clear_inputs(); cyc(); cyc(); rst_n = 1;
  endtask

  // Fetch one word from IDLE: grant this cycle, response the next.
  task automatic fetch_one(input logic [31:0] data);
    irom_gnt = 1; cyc();
    irom_gnt = 0; irom_rvalid = 1; irom_rdata = data; cyc();
    irom_rvalid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_inputs(); cyc(); cyc();
    checks++; if (irom_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", irom_req); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    checks++; if ({id_pc, id_pc4, id_inst} !== 96'h0) begin errors++; $display("FAIL reset_id got=%h exp=0", {id_pc, id_pc4, id_inst}); end
    checks++; if (irom_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", irom_addr); end
  endtask

  task automatic test_first_fetch();
    rst_n = 1; id_ready = 1; irom_gnt = 1; #1;
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h0) begin errors++; $display("FAIL t1_req got=%b/%h exp=1/0", irom_req, irom_addr); end
    cyc();
    irom_gnt = 0; irom_rvalid = 1; irom_rdata = 32'hA0A0_0001; #1;
    checks++; if (irom_req !== 1'b0) begin errors++; $display("FAIL t1_wait_req got=%b exp=0", irom_req); end
    cyc(); irom_rvalid = 0; #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_pc4 !== 32'h4 || id_inst !== 32'hA0A0_0001)
      begin errors++; $display("FAIL t1_out got=%b %h %h %h exp=1 0 4 a0a00001", id_valid, id_pc, id_pc4, id_inst); end
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h4) begin errors++; $display("FAIL t1_next got=%b/%h exp=1/4", irom_req, irom_addr); end
  endtask

  task automatic test_skid();
    do_reset(); id_ready = 0;
    fetch_one(32'h1111_0000);
    irom_gnt = 1; cyc();
    irom_gnt = 0; irom_rvalid = 1; irom_rdata = 32'h2222_0004; cyc();
    irom_rvalid = 0; #1;
    checks++; if (id_valid !== 1'b1 || id_inst !== 32'h1111_0000) begin errors++; $display("FAIL t2_hold got=%b %h exp=1 11110000", id_valid, id_inst); end
    checks++; if (irom_req !== 1'b0) begin errors++; $display("FAIL t2_req_block got=%b exp=0", irom_req); end
    cyc();
    checks++; if (id_inst !== 32'h1111_0000 || irom_req !== 1'b0) begin errors++; $display("FAIL t2_hold2 got=%h/%b exp=11110000/0", id_inst, irom_req); end
    id_ready = 1; cyc();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_pc4 !== 32'h8 || id_inst !== 32'h2222_0004)
      begin errors++; $display("FAIL t2_skid_out got=%b %h %h %h exp=1 4 8 22220004", id_valid, id_pc, id_pc4, id_inst); end
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h8) begin errors++; $display("FAIL t2_resume got=%b/%h exp=1/8", irom_req, irom_addr); end
    cyc();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL t2_drain got=%b exp=0", id_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset(); id_ready = 0;
    fetch_one(32'h3333_0000);
    irom_gnt = 1; cyc(); irom_gnt = 0;
    redirect = 1; redirect_pc = 32'h100; #1;
    checks++; if (irom_req !== 1'b0) begin errors++; $display("FAIL t3_req got=%b exp=0", irom_req); end
    cyc(); redirect = 0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL t3_flush got=%b exp=0", id_valid); end
    checks++; if (irom_req !== 1'b0) begin errors++; $display("FAIL t3_drop_req got=%b exp=0", irom_req); end
    cyc();
    irom_rvalid = 1; irom_rdata = 32'hDEAD_BEEF; cyc(); irom_rvalid = 0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL t3_stale got=%b %h exp=0", id_valid, id_inst); end
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h100) begin errors++; $display("FAIL t3_next got=%b/%h exp=1/100", irom_req, irom_addr); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset(); id_ready = 1;
    irom_gnt = 1; cyc(); irom_gnt = 0;
    irom_rvalid = 1; irom_rdata = 32'h4444_0000; redirect = 1; redirect_pc = 32'h100; cyc();
    irom_rvalid = 0; redirect = 0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL t4_discard got=%b exp=0", id_valid); end
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h100) begin errors++; $display("FAIL t4_next got=%b/%h exp=1/100", irom_req, irom_addr); end
  endtask

  task automatic test_align_wrap();
    do_reset(); id_ready = 1;
    redirect = 1; redirect_pc = 32'h103; #1;
    checks++; if (irom_req !== 1'b0) begin errors++; $display("FAIL t5_req_redir got=%b exp=0", irom_req); end
    cyc(); redirect = 0; #1;
    checks++; if (irom_addr !== 32'h100) begin errors++; $display("FAIL t5_align got=%h exp=100", irom_addr); end
    redirect = 1; redirect_pc = 32'hFFFF_FFFC; cyc(); redirect = 0; #1;
    checks++; if (irom_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL t5_top got=%h exp=fffffffc", irom_addr); end
    fetch_one(32'h5555_0000); #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0)
      begin errors++; $display("FAIL t5_wrap got=%b %h %h exp=1 fffffffc 0", id_valid, id_pc, id_pc4); end
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h0) begin errors++; $display("FAIL t5_next got=%b/%h exp=1/0", irom_req, irom_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset(); id_ready = 0;
    fetch_one(32'h6666_0000);
    irom_gnt = 1; cyc(); irom_gnt = 0;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL t6_pre got=%b exp=1", id_valid); end
    #2 rst_n = 0; #1;
    checks++; if (id_valid !== 1'b0 || irom_req !== 1'b0 || id_inst !== 32'h0)
      begin errors++; $display("FAIL t6_async got=%b %b %h exp=0 0 0", id_valid, irom_req, id_inst); end
    cyc(); rst_n = 1; #1;
    checks++; if (irom_req !== 1'b1 || irom_addr !== 32'h0) begin errors++; $display("FAIL t6_after got=%b/%h exp=1/0", irom_req, irom_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset(); id_ready = 1;
    for (int i = 0; i < 3; i++) begin
      fetch_one(32'h7000_0000 + i); #1;
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'(i * 4) || id_inst !== 32'h7000_0000 + i)
        begin errors++; $display("FAIL b2b_%0d got=%b %h %h exp=1 %h %h", i, id_valid, id_pc, id_inst, i * 4, 32'h7000_0000 + i); end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_skid();
    test_redirect_wait();
    test_redirect_rvalid();
    test_align_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
